// File: rtl/asteroid_pkg.sv
// Shared types and default constants for the asteroid scheduler.
package asteroid_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, UPDATE, SPAWN} state_t;

    localparam int DEF_TOP_Y    = 35;
    localparam int DEF_BOTTOM_Y = 515;
    localparam int DEF_X_MIN    = 144;
    localparam int DEF_SIZE     = 30;

    // Galois LFSR, taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/asteroid_lfsr.sv
// Free-running 16-bit Galois LFSR used for random spawn columns.
// Only built when ASTEROID_LFSR_EN is defined.
`ifdef ASTEROID_LFSR_EN
module asteroid_lfsr
    import asteroid_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= LFSR_SEED;
        else if (enable)
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule
`endif

// File: rtl/asteroid_scheduler.sv
// Frame-locked asteroid pool: spawn, per-slot advance, retire, destroy, pixel hit.
// ASTEROID_LFSR_EN selects LFSR spawn columns; otherwise columns rotate by COL_STEP.
module asteroid_scheduler
    import asteroid_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SIZE         = DEF_SIZE,
    parameter int SPEED        = 1,
    parameter int SPAWN_FRAMES = 60,
    parameter int TOP_Y        = DEF_TOP_Y,
    parameter int BOTTOM_Y     = DEF_BOTTOM_Y,
    parameter int X_MIN        = DEF_X_MIN,
    parameter int COL_STEP     = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           HCounter,
    input  logic [9:0]           VCounter,
    input  logic                 frame_tick,
    input  logic                 switch,
    input  logic                 destroy_valid,
    input  logic [2:0]           destroy_slot,
    output logic                 destroy_ready,
    output logic                 pixel_on,
    output logic [NUM_SLOTS-1:0] active,
    output logic                 miss_pulse,
    output logic [7:0]           miss_count,
    output logic                 overrun
);

    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(SPAWN_FRAMES + 1);

    state_t                      state, state_nx;
    logic [IW-1:0]               idx;
    logic [NUM_SLOTS-1:0]        live;
    logic [NUM_SLOTS-1:0][9:0]   xs, ys;
    logic [CW-1:0]               spawn_cnt;
    logic [9:0]                  spawn_x;
    logic                        free_found;
    logic [IW-1:0]               free_idx;
    logic                        hit;

`ifdef ASTEROID_LFSR_EN
    logic [15:0] lfsr;
    wire         unused_lfsr = ^lfsr[15:9];

    asteroid_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (1'b1),
        .state  (lfsr)
    );

    assign spawn_x = 10'(X_MIN) + {1'b0, lfsr[8:0]};
`else
    logic [1:0] col_k;

    assign spawn_x = 10'(X_MIN + int'(col_k) * COL_STEP);
`endif

    assign active = live;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        destroy_ready = 1'b0;
        case (state)
            IDLE:    if (switch) state_nx = WAIT;
            WAIT: begin
                destroy_ready = 1'b1;
                if (frame_tick) state_nx = UPDATE;
            end
            UPDATE:  if (idx == IW'(NUM_SLOTS - 1)) state_nx = SPAWN;
            SPAWN:   state_nx = WAIT;
            default: state_nx = IDLE;
        endcase
        if (!switch) state_nx = IDLE;
    end

    // Lowest-index free slot; scanning downward leaves the smallest index last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!live[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live       <= '0;
            xs         <= '0;
            ys         <= '0;
            idx        <= '0;
            spawn_cnt  <= CW'(SPAWN_FRAMES);
            miss_pulse <= 1'b0;
            miss_count <= '0;
`ifndef ASTEROID_LFSR_EN
            col_k      <= '0;
`endif
        end else begin
            miss_pulse <= 1'b0;
            if (!switch || state == IDLE) begin
                live      <= '0;
                idx       <= '0;
                spawn_cnt <= CW'(SPAWN_FRAMES);
            end else begin
                case (state)
                    WAIT: begin
                        for (int i = 0; i < NUM_SLOTS; i++)
                            if (destroy_valid && destroy_slot == 3'(i)) live[i] <= 1'b0;
                        if (frame_tick) begin
                            idx <= '0;
                            if (spawn_cnt != '0) spawn_cnt <= spawn_cnt - CW'(1);
                        end
                    end
                    UPDATE: begin
                        idx <= idx + IW'(1);
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (idx == IW'(i) && live[i]) begin
                                // 11-bit sum so the bottom test cannot wrap
                                if (11'(ys[i]) + 11'(SIZE + SPEED) >= 11'(BOTTOM_Y)) begin
                                    live[i]    <= 1'b0;
                                    miss_pulse <= 1'b1;
                                    if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                                end else begin
                                    ys[i] <= ys[i] + 10'(SPEED);
                                end
                            end
                        end
                    end
                    SPAWN: begin
                        if (spawn_cnt == '0 && free_found) begin
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                if (free_idx == IW'(i)) begin
                                    live[i] <= 1'b1;
                                    xs[i]   <= spawn_x;
                                    ys[i]   <= 10'(TOP_Y);
                                end
                            end
                            spawn_cnt <= CW'(SPAWN_FRAMES);
`ifndef ASTEROID_LFSR_EN
                            col_k     <= col_k + 2'd1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (live[i]
                && ({1'b0, xs[i]} < {1'b0, HCounter})
                && ({1'b0, HCounter} < {1'b0, xs[i]} + 11'(SIZE))
                && ({1'b0, ys[i]} < {1'b0, VCounter})
                && ({1'b0, VCounter} < {1'b0, ys[i]} + 11'(SIZE)))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_on <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            pixel_on <= hit;
            if (frame_tick && state != WAIT) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_asteroid_scheduler.sv
// Randomized frame-level bench for asteroid_scheduler against a slot-list reference model.
module tb_asteroid_scheduler;

    localparam int NS = 4, SZ = 30, SP = 1, SF = 2;
    localparam int TOPY = 35, BOTY = 515, XMIN = 144, CSTEP = 128;

    logic          clk = 1'b0, reset = 1'b1;
    logic [9:0]    HCounter = '0, VCounter = '0;
    logic          frame_tick = 1'b0, switch = 1'b0, destroy_valid = 1'b0;
    logic [2:0]    destroy_slot = '0;
    logic          destroy_ready, pixel_on, miss_pulse, overrun;
    logic [NS-1:0] active;
    logic [7:0]    miss_count;

    int n_tests = 0, n_fail = 0;

    // reference model: list of slots and frame-level counters
    bit m_live[NS];
    int m_x[NS], m_y[NS];
    int m_cnt = SF, m_k = 0, m_miss = 0, m_over = 0;

    always #5 clk = ~clk;

    asteroid_scheduler #(
        .NUM_SLOTS(NS), .SIZE(SZ), .SPEED(SP), .SPAWN_FRAMES(SF),
        .TOP_Y(TOPY), .BOTTOM_Y(BOTY), .X_MIN(XMIN), .COL_STEP(CSTEP)
    ) dut (
        .clk(clk), .reset(reset), .HCounter(HCounter), .VCounter(VCounter),
        .frame_tick(frame_tick), .switch(switch), .destroy_valid(destroy_valid),
        .destroy_slot(destroy_slot), .destroy_ready(destroy_ready), .pixel_on(pixel_on),
        .active(active), .miss_pulse(miss_pulse), .miss_count(miss_count), .overrun(overrun)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int mask();
        int m = 0;
        for (int i = 0; i < NS; i++) if (m_live[i]) m |= (1 << i);
        return m;
    endfunction

    function automatic int pix(input int h, input int v);
        for (int i = 0; i < NS; i++)
            if (m_live[i] && m_x[i] < h && h < m_x[i] + SZ && m_y[i] < v && v < m_y[i] + SZ)
                return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_live[i] = 0;
        m_cnt = SF; m_k = 0; m_miss = 0; m_over = 0;
    endtask

    // aim near a live asteroid most of the time, edges included
    task automatic pick_hv(output int h, output int v);
        int ids[$];
        for (int i = 0; i < NS; i++) if (m_live[i]) ids.push_back(i);
        if (ids.size() > 0 && $urandom_range(0, 3) != 0) begin
            int s;
            s = ids[$urandom_range(0, ids.size() - 1)];
            h = m_x[s] + int'($urandom_range(0, SZ));
            v = m_y[s] + int'($urandom_range(0, SZ));
        end else begin
            h = int'($urandom_range(0, 1023));
            v = int'($urandom_range(0, 1023));
        end
        if (h > 1023) h = 1023;
        if (v > 1023) v = 1023;
    endtask

    task automatic idle_cycle(input bit dv, input int ds);
        int h, v, ep;
        pick_hv(h, v);
        HCounter = 10'(h); VCounter = 10'(v);
        destroy_valid = dv; destroy_slot = 3'(ds); frame_tick = 1'b0;
        ep = pix(h, v);
        chk("ready_wait", int'(destroy_ready), 1);
        @(posedge clk); #1;
        if (dv && ds < NS) m_live[ds] = 0;
        destroy_valid = 1'b0;
        chk("pix_wait", int'(pixel_on), ep);
        chk("active_wait", int'(active), mask());
        chk("miss_pulse_wait", int'(miss_pulse), 0);
        chk("overrun_wait", int'(overrun), m_over);
    endtask

    task automatic probe(input int h, input int v, input int exp);
        HCounter = 10'(h); VCounter = 10'(v);
        destroy_valid = 1'b0; frame_tick = 1'b0;
        @(posedge clk); #1;
        chk("probe_pix", int'(pixel_on), exp);
    endtask

    task automatic frame(input bit dv, input int ds, input bit poke);
        int h, v, ep, fs, e;
        bit mexp[NS];
        pick_hv(h, v);
        HCounter = 10'(h); VCounter = 10'(v);
        frame_tick = 1'b1; destroy_valid = dv; destroy_slot = 3'(ds);
        ep = pix(h, v);
        chk("ready_tick", int'(destroy_ready), 1);
        @(posedge clk); #1;
        if (dv && ds < NS) m_live[ds] = 0;
        chk("pix_tick", int'(pixel_on), ep);
        chk("active_tick", int'(active), mask());
        // whole-frame effect: advance/retire every slot, then try one spawn
        if (m_cnt > 0) m_cnt--;
        for (int i = 0; i < NS; i++) begin
            mexp[i] = 0;
            if (m_live[i]) begin
                if (m_y[i] + SZ + SP >= BOTY) begin
                    m_live[i] = 0; mexp[i] = 1;
                    if (m_miss < 255) m_miss++;
                end else m_y[i] += SP;
            end
        end
        fs = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m_live[i]) fs = i;
        if (m_cnt == 0 && fs >= 0) begin
            m_live[fs] = 1; m_x[fs] = XMIN + m_k * CSTEP; m_y[fs] = TOPY;
            m_k = (m_k + 1) % 4; m_cnt = SF;
        end
        HCounter = '0; VCounter = '0;
        for (int k = 0; k <= NS; k++) begin
            destroy_valid = 1'($urandom_range(0, 1));
            destroy_slot  = 3'($urandom_range(0, 7));
            frame_tick    = poke && k == 1;
            if (frame_tick) m_over = 1;
            chk("ready_busy", int'(destroy_ready), 0);
            @(posedge clk); #1;
            e = 0;
            if (k < NS) e = int'(mexp[k]);
            chk("pix_busy", int'(pixel_on), 0);
            chk("miss_pulse", int'(miss_pulse), e);
        end
        destroy_valid = 1'b0; frame_tick = 1'b0;
        chk("active_frame", int'(active), mask());
        chk("miss_count", int'(miss_count), m_miss);
        chk("overrun", int'(overrun), m_over);
        chk("ready_back", int'(destroy_ready), 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_pixel_on", int'(pixel_on), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_miss_pulse", int'(miss_pulse), 0);
        chk("rst_miss_count", int'(miss_count), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_ready", int'(destroy_ready), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0; switch = 1'b1;
        @(posedge clk); #1;
        chk("ready_first", int'(destroy_ready), 1);

        // first spawn after two frames at column 0, second at column 1
        frame(0, 0, 0);
        idle_cycle(0, 0);
        frame(0, 0, 0);
        probe(145, 36, 1); probe(144, 36, 0); probe(145, 35, 0);
        probe(173, 64, 1); probe(174, 64, 0);
        frame(0, 0, 0);
        frame(0, 0, 0);
        probe(273, 36, 1); probe(272, 36, 0);

        // churn: frequent destroys, in-range and out-of-range
        repeat (150) begin
            repeat ($urandom_range(0, 3)) idle_cycle($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)));
            frame($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), 0);
        end

        // stop: pool cleared, misses retained, restart from IDLE
        switch = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) m_live[i] = 0;
        m_cnt = SF;
        chk("stop_active", int'(active), 0);
        chk("stop_ready", int'(destroy_ready), 0);
        chk("stop_miss_count", int'(miss_count), m_miss);
        switch = 1'b1;
        @(posedge clk); #1;
        chk("restart_ready", int'(destroy_ready), 1);

        // no destroys: asteroids fall to the bottom, full pool holds spawns
        for (int f = 0; f < 520; f++) begin
            repeat ($urandom_range(0, 2)) idle_cycle(0, 0);
            frame(0, 0, f == 260);
        end
        idle_cycle(1, 2);
        frame(1, 1, 0);

        // reset while the update sweep is in progress
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        check_reset_outputs();
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("ready_after_rst", int'(destroy_ready), 1);
        frame(0, 0, 0);
        frame(0, 0, 0);
        probe(145, 36, 1);
        repeat (10) frame($urandom_range(0, 1) == 0, int'($urandom_range(0, 7)), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/asteroid_scheduler.md
# asteroid_scheduler

Owns the pool of falling asteroids for the playfield: decides when and where new asteroids spawn, advances every live asteroid once per frame, retires those that reach the bottom, and accepts destroy requests from the shot/collision logic. Sits between the VGA sync counters and the pixel mixer. Replaces per-object free-running square movers with one sequenced, frame-locked controller and a single registered "asteroid pixel" output.

## Interface
Parameters:
- NUM_SLOTS, 4: asteroid slots (1..8).
- SIZE, 30: asteroid edge length in pixels.
- SPEED, 1: pixels moved down per frame.
- SPAWN_FRAMES, 60: frames between spawn attempts (≥1).
- TOP_Y, 35 / BOTTOM_Y, 515: vertical active window (VCounter units).
- X_MIN, 144 / COL_STEP, 128: left edge of playfield; column pitch in non-LFSR mode.

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- HCounter  in  10  current horizontal pixel count.
- VCounter  in  10  current vertical line count.
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- switch  in  1  run enable; low = game stopped, pool cleared.
- destroy_valid  in  1  destroy request.
- destroy_slot  in  3  slot to destroy.
- destroy_ready  out  1  request accepted this cycle when valid & ready.
- pixel_on  out  1  current pixel lies inside a live asteroid (registered).
- active  out  NUM_SLOTS  live-slot mask.
- miss_pulse  out  1  one-cycle pulse when an asteroid leaves the bottom.
- miss_count  out  8  saturating count of misses.
- overrun  out  1  sticky: frame_tick arrived while not in WAIT.

## Operation
- Per slot: live bit, x[9:0], y[9:0] (top-left corner).
- FSM states: IDLE, WAIT, UPDATE, SPAWN.
- IDLE: all slots dead, spawn counter = SPAWN_FRAMES, destroy_ready=0. switch=1 -> WAIT.
- WAIT: destroy_ready=1. frame_tick -> UPDATE with idx=0; spawn counter decrements if nonzero.
- UPDATE: one slot per cycle, idx 0..NUM_SLOTS-1. Live slot: if y+SIZE+SPEED >= BOTTOM_Y -> clear live, miss_pulse, miss_count+1 (saturate at 255); else y += SPEED. After last idx -> SPAWN.
- SPAWN (one cycle): if counter == 0 and a free slot exists, lowest-index free slot gets live=1, y=TOP_Y, x from column generator; counter reloads SPAWN_FRAMES. No free slot: counter stays 0, retried next frame. -> WAIT.
- destroy: accepted only in WAIT; clears live of destroy_slot; destroy of dead or out-of-range slot is accepted and ignored.
- switch low in any state -> IDLE next cycle; slots cleared; miss_count retained.
- frame_tick outside WAIT: ignored, overrun set (cleared only by reset).
- pixel_on: registered OR over live slots of (x < HCounter < x+SIZE) and (y < VCounter < y+SIZE), strict compares, 11-bit sums to avoid wrap.

## Timing
- Reset: state IDLE, all slots dead, x=y=0, pixel_on=0, active=0, miss_pulse=0, miss_count=0, overrun=0, destroy_ready=0, spawn counter=SPAWN_FRAMES, LFSR seed 16'hACE1.
- pixel_on latency: 1 clk after HCounter/VCounter.
- Frame update: frame_tick at cycle t -> UPDATE at t+1..t+NUM_SLOTS -> SPAWN at t+NUM_SLOTS+1 -> WAIT at t+NUM_SLOTS+2.
- miss_pulse asserted the cycle after that slot's UPDATE cycle, exactly one cycle.
- active reflects register state directly (no extra latency).

## Configuration
- ASTEROID_LFSR_EN defined: 16-bit Galois LFSR (taps 16,14,13,11) steps every clk; spawn x = X_MIN + {1'b0, lfsr[8:0]}.
- Undefined: spawn x = X_MIN + k*COL_STEP, k cycles 0,1,2,3,0… per successful spawn; no LFSR logic.

## Structure
- asteroid_pkg: FSM state enum, default geometry constants (TOP_Y, BOTTOM_Y, X_MIN, SIZE), LFSR seed/taps.
- One sub-module: asteroid_lfsr (enable, 16-bit state out), instantiated only under ASTEROID_LFSR_EN.

## Test plan
- Reset mid-UPDATE -> next cycle all outputs at reset values, state IDLE.
- switch=1, SPAWN_FRAMES=2, macro undefined, 2 frame_ticks -> slot0 live at x=144, y=35; next spawn x=272.
- Live slot y=484, SIZE=30, SPEED=1 -> after one frame_tick slot freed, miss_pulse 1 cycle, miss_count=1.
- destroy_valid, slot 2 live, in WAIT -> destroy_ready=1, active[2]=0 next cycle; same request during UPDATE -> destroy_ready=0, slot unchanged.
- All 4 slots live when spawn due -> no spawn, counter held at 0; spawn into freed slot on first frame after a destroy.
- Slot at x=200, y=100: HCounter=215, VCounter=115 -> pixel_on=1 one clk later; HCounter=200 -> pixel_on=0.
